// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, branch redirect and the instruction handshake to decode.
// master is the fetch unit, slave is the ROM/execute/decode side.
interface fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  branch_en;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_ext;
    logic                  instr_two;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        input  branch_en,
        input  branch_target,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_ext,
        output instr_two,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output branch_en,
        output branch_target,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_ext,
        input  instr_two,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM, merges two-word opcodes into one packet and
// hands packets to decode over valid/ready. Branch redirects from execute take priority.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] LDS_MASK = DATA_WIDTH'(16'hFC0F);
    localparam logic [DATA_WIDTH-1:0] LDS_OPC  = DATA_WIDTH'(16'h9000);
    localparam logic [DATA_WIDTH-1:0] JMP_MASK = DATA_WIDTH'(16'hFE0C);
    localparam logic [DATA_WIDTH-1:0] JMP_OPC  = DATA_WIDTH'(16'h940C);

    typedef enum logic [0:0] {StW0, StW1} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  fetch_vld_q, fetch_vld_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_ext_q, instr_ext_d;
    logic                  instr_two_q, instr_two_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] pend_w_q, pend_w_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic accept;
    logic take;
    logic is_two;

    always_comb begin
        accept = !instr_valid_q || bus.instr_ready;
        take   = fetch_vld_q && ((state_q == StW1) || accept);
        is_two = ((bus.rom_data & LDS_MASK) == LDS_OPC) ||
                 ((bus.rom_data & JMP_MASK) == JMP_OPC);
    end

    // Whenever fetch_vld_q is set, pc_q already points one past fetch_pc_q. A refused word is
    // re-requested, and the successor already in flight is dropped so it cannot overtake it.
    always_comb begin
        fetch_pc_d  = pc_q;
        fetch_vld_d = !bus.branch_en && !(fetch_vld_q && !take);
        if (bus.branch_en) begin
            pc_d = bus.branch_target;
        end else if (fetch_vld_q && !take) begin
            pc_d = fetch_pc_q;
        end else begin
            pc_d = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_ext_d   = instr_ext_q;
        instr_two_d   = instr_two_q;
        instr_pc_d    = instr_pc_q;
        pend_w_d      = pend_w_q;
        pend_pc_d     = pend_pc_q;

        if (instr_valid_q && bus.instr_ready) begin
            instr_valid_d = 1'b0;
        end

        unique case (state_q)
            StW0: begin
                if (take) begin
                    if (is_two) begin
                        pend_w_d  = bus.rom_data;
                        pend_pc_d = fetch_pc_q;
                        state_d   = StW1;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_d       = bus.rom_data;
                        instr_ext_d   = '0;
                        instr_two_d   = 1'b0;
                        instr_pc_d    = fetch_pc_q;
                    end
                end
            end
            StW1: begin
                // Entering StW1 always empties the output slot, so the merged packet never
                // has to wait for decode.
                if (take) begin
                    instr_valid_d = 1'b1;
                    instr_d       = pend_w_q;
                    instr_ext_d   = bus.rom_data;
                    instr_two_d   = 1'b1;
                    instr_pc_d    = pend_pc_q;
                    state_d       = StW0;
                end
            end
            default: state_d = StW0;
        endcase

        if (bus.branch_en) begin
            instr_valid_d = 1'b0;
            state_d       = StW0;
            pend_w_d      = '0;
            pend_pc_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StW0;
            pc_q          <= PC_RESET;
            fetch_pc_q    <= '0;
            fetch_vld_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_ext_q   <= '0;
            instr_two_q   <= 1'b0;
            instr_pc_q    <= '0;
            pend_w_q      <= '0;
            pend_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_vld_q   <= fetch_vld_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_ext_q   <= instr_ext_d;
            instr_two_q   <= instr_two_d;
            instr_pc_q    <= instr_pc_d;
            pend_w_q      <= pend_w_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_ext   = instr_ext_q;
    assign bus.instr_two   = instr_two_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table on a PC_RESET=0 instance and short
// hand-written sequences for address wrap (PC_RESET=0xFF instance) and asynchronous reset.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();
    fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if2 ();

    fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PC_RESET(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );
    fetch_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .PC_RESET(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2)
    );

    // ROM: address captured on posedge, word presented on the following negedge.
    logic [15:0] rom1 [256];
    logic [15:0] rom2 [256];
    logic [7:0]  a1, a2;
    always @(posedge clk) begin
        a1 <= if1.rom_addr;
        a2 <= if2.rom_addr;
    end
    always @(negedge clk) begin
        if1.rom_data <= rom1[a1];
        if2.rom_data <= rom2[a2];
    end

    typedef struct {
        logic        ready;
        logic        br;
        logic [7:0]  tgt;
        logic        ev;
        logic [15:0] ei;
        logic [15:0] ee;
        logic        et;
        logic [7:0]  ep;
        logic [7:0]  ea;
    } vec_t;

    vec_t vecs [22];
    vec_t vecs2 [4];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic rdy, input logic br, input logic [7:0] tgt,
                                input logic ev, input logic [15:0] ei, input logic [15:0] ee,
                                input logic et, input logic [7:0] ep, input logic [7:0] ea);
        vec_t v;
        v.ready = rdy; v.br = br; v.tgt = tgt; v.ev = ev; v.ei = ei; v.ee = ee;
        v.et = et; v.ep = ep; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic check1(input string tag, input vec_t e);
        chk({tag, " valid"}, 32'(if1.instr_valid), 32'(e.ev));
        chk({tag, " rom_addr"}, 32'(if1.rom_addr), 32'(e.ea));
        if (e.ev) begin
            chk({tag, " instr"}, 32'(if1.instr), 32'(e.ei));
            chk({tag, " instr_ext"}, 32'(if1.instr_ext), 32'(e.ee));
            chk({tag, " instr_two"}, 32'(if1.instr_two), 32'(e.et));
            chk({tag, " instr_pc"}, 32'(if1.instr_pc), 32'(e.ep));
        end
    endtask

    task automatic check2(input string tag, input vec_t e);
        chk({tag, " valid"}, 32'(if2.instr_valid), 32'(e.ev));
        chk({tag, " rom_addr"}, 32'(if2.rom_addr), 32'(e.ea));
        if (e.ev) begin
            chk({tag, " instr"}, 32'(if2.instr), 32'(e.ei));
            chk({tag, " instr_ext"}, 32'(if2.instr_ext), 32'(e.ee));
            chk({tag, " instr_two"}, 32'(if2.instr_two), 32'(e.et));
            chk({tag, " instr_pc"}, 32'(if2.instr_pc), 32'(e.ep));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom1[i] = 16'h1000 + 16'(i);
            rom2[i] = 16'h0000;
        end
        rom1[0] = 16'hE0C3; rom1[1] = 16'hB9C6; rom1[2] = 16'hB116;
        rom1[3] = 16'h9100; rom1[4] = 16'h0060; rom1[5] = 16'h0000;
        rom1[7] = 16'h940E; rom1[8] = 16'h0042;
        rom1[8'h10] = 16'h2F10;
        rom1[8'h12] = 16'h9200; rom1[8'h13] = 16'h0077;
        rom2[8'hFF] = 16'h940C; rom2[0] = 16'h0123; rom2[1] = 16'h5A5A;

        //               rdy br  tgt    ev  instr     ext       two  pc     addr
        vecs[0]  = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h01);
        vecs[1]  = mk(1, 0, 8'h00, 1, 16'hE0C3, 16'h0000, 0, 8'h00, 8'h02);
        vecs[2]  = mk(1, 0, 8'h00, 1, 16'hB9C6, 16'h0000, 0, 8'h01, 8'h03);
        vecs[3]  = mk(0, 0, 8'h00, 1, 16'hB9C6, 16'h0000, 0, 8'h01, 8'h02);
        vecs[4]  = mk(0, 0, 8'h00, 1, 16'hB9C6, 16'h0000, 0, 8'h01, 8'h03);
        vecs[5]  = mk(0, 0, 8'h00, 1, 16'hB9C6, 16'h0000, 0, 8'h01, 8'h02);
        vecs[6]  = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h03);
        vecs[7]  = mk(1, 0, 8'h00, 1, 16'hB116, 16'h0000, 0, 8'h02, 8'h04);
        vecs[8]  = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h05);
        vecs[9]  = mk(1, 0, 8'h00, 1, 16'h9100, 16'h0060, 1, 8'h03, 8'h06);
        vecs[10] = mk(1, 0, 8'h00, 1, 16'h0000, 16'h0000, 0, 8'h05, 8'h07);
        vecs[11] = mk(1, 0, 8'h00, 1, 16'h1006, 16'h0000, 0, 8'h06, 8'h08);
        vecs[12] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h09);
        vecs[13] = mk(0, 1, 8'h10, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h10);
        vecs[14] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h11);
        vecs[15] = mk(1, 0, 8'h00, 1, 16'h2F10, 16'h0000, 0, 8'h10, 8'h12);
        vecs[16] = mk(1, 0, 8'h00, 1, 16'h1011, 16'h0000, 0, 8'h11, 8'h13);
        vecs[17] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h14);
        vecs[18] = mk(0, 0, 8'h00, 1, 16'h9200, 16'h0077, 1, 8'h12, 8'h15);
        vecs[19] = mk(0, 0, 8'h00, 1, 16'h9200, 16'h0077, 1, 8'h12, 8'h14);
        vecs[20] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h15);
        vecs[21] = mk(1, 0, 8'h00, 1, 16'h1014, 16'h0000, 0, 8'h14, 8'h16);

        vecs2[0] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h00);
        vecs2[1] = mk(1, 0, 8'h00, 0, 16'h0000, 16'h0000, 0, 8'h00, 8'h01);
        vecs2[2] = mk(1, 0, 8'h00, 1, 16'h940C, 16'h0123, 1, 8'hFF, 8'h02);
        vecs2[3] = mk(1, 0, 8'h00, 1, 16'h5A5A, 16'h0000, 0, 8'h01, 8'h03);

        if1.instr_ready = 1'b1; if1.branch_en = 1'b0; if1.branch_target = 8'h00;
        if2.instr_ready = 1'b1; if2.branch_en = 1'b0; if2.branch_target = 8'h00;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("reset valid", 32'(if1.instr_valid), 32'h0);
        chk("reset instr", 32'(if1.instr), 32'h0);
        chk("reset instr_ext", 32'(if1.instr_ext), 32'h0);
        chk("reset instr_two", 32'(if1.instr_two), 32'h0);
        chk("reset instr_pc", 32'(if1.instr_pc), 32'h0);
        chk("reset rom_addr", 32'(if1.rom_addr), 32'h0);
        chk("reset2 valid", 32'(if2.instr_valid), 32'h0);
        chk("reset2 rom_addr", 32'(if2.rom_addr), 32'hFF);

        // Wrap: JMP at 0xFF with its extension word at 0x00.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check2($sformatf("wrap%0d", i), vecs2[i]);
        end

        // Async reset between edges while dut1 holds a valid packet.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(if1.instr_valid), 32'h0);
        chk("midrst rom_addr", 32'(if1.rom_addr), 32'h0);
        chk("midrst2 rom_addr", 32'(if2.rom_addr), 32'hFF);
        @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            if1.instr_ready   = vecs[i].ready;
            if1.branch_en     = vecs[i].br;
            if1.branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check1($sformatf("row%0d", i), vecs[i]);
        end
        if1.branch_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
